// File: rtl/p2m_echo_indication.sv
// rtl/p2m_echo_indication.sv - EchoIndication pipe-to-method deserializer with 2-entry message FIFO
// Optional delivered/dropped counters are built when P2M_ECHO_STATS_EN is defined.
module p2m_echo_indication (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         pipe_enq__ENA,
    input  logic [143:0] pipe_enq_v,
    output logic         pipe_enq__RDY,
    output logic         method_heard__ENA,
    output logic [31:0]  method_heard_v,
    input  logic         method_heard__RDY,
    output logic         method_heard2__ENA,
    output logic [15:0]  method_heard2_a,
    output logic [15:0]  method_heard2_b,
    input  logic         method_heard2__RDY,
    output logic         method_heard3__ENA,
    output logic [15:0]  method_heard3_a,
    output logic [15:0]  method_heard3_b,
    output logic [31:0]  method_heard3_c,
    output logic [31:0]  method_heard3_d,
    input  logic         method_heard3__RDY
`ifdef P2M_ECHO_STATS_EN
    ,
    output logic [15:0]  stat_delivered,
    output logic [15:0]  stat_dropped
`endif
);

    logic [143:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    logic [143:0] head;
    logic [15:0]  head_sel;
    logic [15:0]  head_len;
    logic [15:0]  head_tail;
    logic         has_head;
    logic         hdr_ok;
    logic         drop;
    logic         deliver;
    logic         push;
    logic         pop;

    assign head      = mem[rd_ptr];
    assign head_sel  = head[143:128];
    assign head_len  = head[127:112];
    assign head_tail = head[15:0];
    assign has_head  = (count != 2'd0);

    always_comb begin
        hdr_ok = 1'b0;
        if (head_len == 16'd5) begin
            case (head_sel)
                16'd0, 16'd1: hdr_ok = (head_tail == 16'd2);
                16'd2:        hdr_ok = (head_tail == 16'd4);
                default:      hdr_ok = 1'b0;
            endcase
        end
    end

    assign method_heard__ENA  = has_head && hdr_ok && (head_sel == 16'd0) && method_heard__RDY;
    assign method_heard2__ENA = has_head && hdr_ok && (head_sel == 16'd1) && method_heard2__RDY;
    assign method_heard3__ENA = has_head && hdr_ok && (head_sel == 16'd2) && method_heard3__RDY;

    // Data lines are gated so an idle or stalled method presents zeros.
    assign method_heard_v  = method_heard__ENA  ? head[111:80] : 32'd0;
    assign method_heard2_a = method_heard2__ENA ? head[111:96] : 16'd0;
    assign method_heard2_b = method_heard2__ENA ? head[95:80]  : 16'd0;
    assign method_heard3_a = method_heard3__ENA ? head[111:96] : 16'd0;
    assign method_heard3_b = method_heard3__ENA ? head[95:80]  : 16'd0;
    assign method_heard3_c = method_heard3__ENA ? head[79:48]  : 32'd0;
    assign method_heard3_d = method_heard3__ENA ? head[47:16]  : 32'd0;

    assign deliver       = method_heard__ENA || method_heard2__ENA || method_heard3__ENA;
    assign drop          = has_head && !hdr_ok;
    assign pop           = deliver || drop;
    assign pipe_enq__RDY = (count != 2'd2);
    assign push          = pipe_enq__ENA && pipe_enq__RDY;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= pipe_enq_v;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef P2M_ECHO_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_delivered <= 16'd0;
            stat_dropped   <= 16'd0;
        end else begin
            if (deliver && (stat_delivered != 16'hFFFF)) begin
                stat_delivered <= stat_delivered + 16'd1;
            end
            if (drop && (stat_dropped != 16'hFFFF)) begin
                stat_dropped <= stat_dropped + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_p2m_echo_indication.sv
// tb/tb_p2m_echo_indication.sv - directed self-checking bench for p2m_echo_indication
module tb_p2m_echo_indication;

    logic         clk;
    logic         rst_n;
    logic         enq_ena;
    logic [143:0] enq_v;
    logic         enq_rdy;
    logic         h1_ena;
    logic [31:0]  h1_v;
    logic         h1_rdy;
    logic         h2_ena;
    logic [15:0]  h2_a;
    logic [15:0]  h2_b;
    logic         h2_rdy;
    logic         h3_ena;
    logic [15:0]  h3_a;
    logic [15:0]  h3_b;
    logic [31:0]  h3_c;
    logic [31:0]  h3_d;
    logic         h3_rdy;
`ifdef P2M_ECHO_STATS_EN
    logic [15:0]  st_delivered;
    logic [15:0]  st_dropped;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    p2m_echo_indication dut (
        .CLK                (clk),
        .nRST               (rst_n),
        .pipe_enq__ENA      (enq_ena),
        .pipe_enq_v         (enq_v),
        .pipe_enq__RDY      (enq_rdy),
        .method_heard__ENA  (h1_ena),
        .method_heard_v     (h1_v),
        .method_heard__RDY  (h1_rdy),
        .method_heard2__ENA (h2_ena),
        .method_heard2_a    (h2_a),
        .method_heard2_b    (h2_b),
        .method_heard2__RDY (h2_rdy),
        .method_heard3__ENA (h3_ena),
        .method_heard3_a    (h3_a),
        .method_heard3_b    (h3_b),
        .method_heard3_c    (h3_c),
        .method_heard3_d    (h3_d),
        .method_heard3__RDY (h3_rdy)
`ifdef P2M_ECHO_STATS_EN
        ,
        .stat_delivered     (st_delivered),
        .stat_dropped       (st_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [143:0] mk(input logic [15:0] sel, input logic [15:0] len,
                                        input logic [95:0] pl, input logic [15:0] tail);
        return {sel, len, pl, tail};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        enq_ena = 1'b0;
        enq_v   = '0;
        h1_rdy  = 1'b1;
        h2_rdy  = 1'b1;
        h3_rdy  = 1'b1;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", enq_rdy, 1'b1);
        check("rst_enas", {h1_ena, h2_ena, h3_ena}, 3'b000);
        check("rst_data", {h1_v, h2_a, h2_b, h3_a, h3_b, h3_c, h3_d}, 160'd0);
        rst_n = 1'b1;
        tick();

        enq_ena = 1'b1;
        enq_v   = mk(16'd0, 16'd5, {32'hDEADBEEF, 64'd0}, 16'd2);
        settle();
        check("h1_no_bypass", h1_ena, 1'b0);
        tick();
        enq_ena = 1'b0;
        settle();
        check("h1_ena", h1_ena, 1'b1);
        check("h1_v", h1_v, 32'hDEADBEEF);
        check("h1_others", {h2_ena, h3_ena}, 2'b00);
        tick();
        settle();
        check("h1_done", {h1_ena, h2_ena, h3_ena}, 3'b000);

        tick();
        enq_ena = 1'b1;
        enq_v   = mk(16'd2, 16'd5, {16'h1, 16'h2, 32'h3, 32'h4}, 16'd4);
        tick();
        enq_ena = 1'b0;
        settle();
        check("h3_ena", {h1_ena, h2_ena, h3_ena}, 3'b001);
        check("h3_abcd", {h3_a, h3_b, h3_c, h3_d}, {16'h1, 16'h2, 32'h3, 32'h4});
        tick();

        h2_rdy  = 1'b0;
        enq_ena = 1'b1;
        enq_v   = mk(16'd1, 16'd5, {16'h0011, 16'h0022, 64'd0}, 16'd2);
        tick();
        enq_v   = mk(16'd1, 16'd5, {16'h0033, 16'h0044, 64'd0}, 16'd2);
        settle();
        check("bp_rdy1", enq_rdy, 1'b1);
        check("bp_stall_ena", h2_ena, 1'b0);
        check("bp_stall_data", {h2_a, h2_b}, 32'd0);
        tick();
        enq_ena = 1'b0;
        settle();
        check("bp_full", enq_rdy, 1'b0);
        tick();
        settle();
        check("bp_hold", {enq_rdy, h2_ena}, 2'b00);
        h2_rdy = 1'b1;
        #1;
        check("bp_w1", {h2_ena, h2_a, h2_b}, {1'b1, 16'h0011, 16'h0022});
        check("bp_no_bypass", enq_rdy, 1'b0);
        tick();
        enq_ena = 1'b1;
        enq_v   = mk(16'd1, 16'd5, {16'h0055, 16'h0066, 64'd0}, 16'd2);
        settle();
        check("bp_rdy_back", enq_rdy, 1'b1);
        check("bp_w2", {h2_ena, h2_a, h2_b}, {1'b1, 16'h0033, 16'h0044});
        tick();
        enq_ena = 1'b0;
        settle();
        check("bp_w3", {h2_ena, h2_a, h2_b}, {1'b1, 16'h0055, 16'h0066});
        tick();
        settle();
        check("bp_empty", {h1_ena, h2_ena, h3_ena, enq_rdy}, 4'b0001);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        enq_ena = 1'b1;
        enq_v   = mk(16'd7, 16'd5, {32'h12345678, 64'd0}, 16'd2);
        tick();
        enq_v   = mk(16'd0, 16'd5, {32'hCAFEF00D, 64'd0}, 16'd2);
        settle();
        check("drop_sel7", {h1_ena, h2_ena, h3_ena}, 3'b000);
        tick();
        enq_ena = 1'b0;
        settle();
        check("after_drop", {h1_ena, h1_v}, {1'b1, 32'hCAFEF00D});
        tick();
`ifdef P2M_ECHO_STATS_EN
        check("stat_dropped", st_dropped, 16'd1);
        check("stat_delivered", st_delivered, 16'd1);
`endif

        enq_ena = 1'b1;
        enq_v   = mk(16'd0, 16'd4, {32'h11111111, 64'd0}, 16'd2);
        tick();
        enq_v   = mk(16'd2, 16'd5, {16'h1, 16'h2, 32'h3, 32'h4}, 16'd2);
        settle();
        check("drop_len", {h1_ena, h2_ena, h3_ena}, 3'b000);
        tick();
        enq_ena = 1'b0;
        settle();
        check("drop_tail", {h1_ena, h2_ena, h3_ena}, 3'b000);
        tick();
        settle();
        check("drop_empty", {h1_ena, h2_ena, h3_ena, enq_rdy}, 4'b0001);
`ifdef P2M_ECHO_STATS_EN
        check("stat_dropped3", st_dropped, 16'd3);
        check("stat_delivered1", st_delivered, 16'd1);
`endif

        h1_rdy  = 1'b0;
        enq_ena = 1'b1;
        enq_v   = mk(16'd0, 16'd5, {32'hAAAA0001, 64'd0}, 16'd2);
        tick();
        enq_v   = mk(16'd0, 16'd5, {32'hAAAA0002, 64'd0}, 16'd2);
        tick();
        enq_ena = 1'b0;
        settle();
        check("fill_full", enq_rdy, 1'b0);
        h1_rdy = 1'b1;
        #1;
        check("fill_ready_ena", h1_ena, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ena", {h1_ena, h2_ena, h3_ena}, 3'b000);
        check("rst_mid_rdy", enq_rdy, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        settle();
        check("rst_no_stale", {h1_ena, h2_ena, h3_ena, h1_v}, {3'b000, 32'd0});
        check("rst_rdy_after", enq_rdy, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
